// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier characterisation blocks.
//   OpWidth   : operand width of the multipliers under test
//   ProdWidth : width of the exact and approximate products
//   ErrWidth  : width of the signed error (product width plus sign)
//   mon_state_e : batch-control FSM states of the error monitor
package approx_mult_pkg;

    localparam int unsigned OpWidth   = 8;
    localparam int unsigned ProdWidth = 2 * OpWidth;
    localparam int unsigned ErrWidth  = ProdWidth + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/approx_mult_err_monitor_ed_calc.sv
// ed_calc: combinational arithmetic for one sample of an OpW x OpW approximate multiplier.
// The exact product and the error are exposed as two independent halves so that the
// caller can place a pipeline register between them.
//   a_i, b_i  : unsigned operands
//   exact_o   : exact product a_i * b_i
//   exact_i   : (registered) exact product
//   r_i       : (registered) approximate product
//   err_o     : signed error r_i - exact_i
//   ed_o      : error distance |r_i - exact_i|
module ed_calc #(
    parameter int unsigned OpW = 8
) (
    input  logic [OpW-1:0]          a_i,
    input  logic [OpW-1:0]          b_i,
    output logic [2*OpW-1:0]        exact_o,
    input  logic [2*OpW-1:0]        exact_i,
    input  logic [2*OpW-1:0]        r_i,
    output logic signed [2*OpW:0]   err_o,
    output logic [2*OpW-1:0]        ed_o
);

    localparam int unsigned PW = 2 * OpW;

    logic [PW:0] neg_err;

    always_comb begin
        exact_o = PW'(a_i) * PW'(b_i);
        // Both products are unsigned; one extra bit holds the sign of the difference.
        err_o   = $signed({1'b0, r_i}) - $signed({1'b0, exact_i});
        neg_err = -err_o;
        // |err| never exceeds 2^PW-1, so the magnitude always fits in PW bits.
        ed_o    = err_o[PW] ? neg_err[PW-1:0] : err_o[PW-1:0];
    end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: accumulates error metrics of an 8x8 approximate multiplier over a
// programmed batch of N_SAMPLES operand/result pairs.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start               : one-cycle pulse; clears metrics and starts a batch (IDLE/DONE only)
//   in_valid / in_ready : sample handshake; in_ready is high only while running
//   in_a, in_b, in_r    : operands and approximate product under test
//   busy, done          : batch in progress / metrics final and held
//   sample_cnt, err_cnt : samples accumulated / samples with a non-zero error
//   sum_ed, sum_err     : saturating sums of |err| (unsigned) and err (two's complement)
//   max_ed              : largest error distance seen
// Pipeline: S1 registers the exact product and in_r; S2 is the metric registers themselves,
// so a sample is reflected in the metrics two edges after its transfer.
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 65536,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned CNT_W     = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OpWidth-1:0]   in_a,
    input  logic [OpWidth-1:0]   in_b,
    input  logic [ProdWidth-1:0] in_r,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [ACC_W-1:0]     sum_err,
    output logic [ProdWidth-1:0] max_ed
);

    // Widths with headroom for one more addend before the saturation check.
    localparam int unsigned EdSumW  = ((ACC_W > ProdWidth) ? ACC_W : ProdWidth) + 1;
    localparam int unsigned ErrSumW = ((ACC_W > ErrWidth) ? ACC_W : ErrWidth) + 1;

    localparam logic [CNT_W-1:0]          LastIdx   = CNT_W'(N_SAMPLES - 1);
    localparam logic [EdSumW-1:0]         EdSumMax  = EdSumW'({ACC_W{1'b1}});
    localparam logic signed [ErrSumW-1:0] ErrPosLim =
        ErrSumW'((64'(1) << (ACC_W - 1)) - 64'(1));
    localparam logic signed [ErrSumW-1:0] ErrNegLim = ~ErrPosLim;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    mon_state_e state_q, state_d;

    logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [ProdWidth-1:0] s1_exact_q, s1_exact_d;
    logic [ProdWidth-1:0] s1_r_q, s1_r_d;

    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0]     sum_ed_q, sum_ed_d;
    logic [ACC_W-1:0]     sum_err_q, sum_err_d;
    logic                 err_sat_q, err_sat_d;
    logic [ProdWidth-1:0] max_ed_q, max_ed_d;

    logic                        xfer;
    logic                        last_xfer;
    logic                        clear_metrics;
    logic [ProdWidth-1:0]        exact_in;
    logic signed [ErrWidth-1:0]  err;
    logic [ProdWidth-1:0]        ed;
    logic [EdSumW-1:0]           ed_sum_wide;
    logic signed [ErrSumW-1:0]   err_sum_wide;

    // ------------------------------------------------------------------
    // Per-sample arithmetic
    // ------------------------------------------------------------------
    ed_calc #(
        .OpW (OpWidth)
    ) u_ed_calc (
        .a_i     (in_a),
        .b_i     (in_b),
        .exact_o (exact_in),
        .exact_i (s1_exact_q),
        .r_i     (s1_r_q),
        .err_o   (err),
        .ed_o    (ed)
    );

    assign xfer          = in_valid & in_ready;
    assign last_xfer     = xfer & (acc_cnt_q == LastIdx);
    assign clear_metrics = start & ((state_q == StIdle) | (state_q == StDone));

    // ------------------------------------------------------------------
    // Batch FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_xfer) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // S2 commits on the same edge it consumes S1, so an empty S1 means
                // the last sample is already in the metrics.
                if (!s1_valid_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            StRun: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StDrain: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Accept counter and S1 pipeline register
    // ------------------------------------------------------------------
    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        s1_valid_d = xfer;
        s1_exact_d = s1_exact_q;
        s1_r_d     = s1_r_q;
        if (clear_metrics) begin
            acc_cnt_d = '0;
        end else if (xfer) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (xfer) begin
            s1_exact_d = exact_in;
            s1_r_d     = in_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_exact_q <= '0;
            s1_r_q     <= '0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_exact_q <= s1_exact_d;
            s1_r_q     <= s1_r_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: metric accumulation
    // ------------------------------------------------------------------
    always_comb begin
        ed_sum_wide  = EdSumW'(sum_ed_q) + EdSumW'(ed);
        err_sum_wide = {{(ErrSumW - ACC_W){sum_err_q[ACC_W-1]}}, sum_err_q}
                     + {{(ErrSumW - ErrWidth){err[ErrWidth-1]}}, err};
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_ed_d     = sum_ed_q;
        sum_err_d    = sum_err_q;
        err_sat_d    = err_sat_q;
        max_ed_d     = max_ed_q;
        if (clear_metrics) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_ed_d     = '0;
            sum_err_d    = '0;
            err_sat_d    = 1'b0;
            max_ed_d     = '0;
        end else if (s1_valid_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (ed != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            // Once at the ceiling, any further non-negative addend keeps it there.
            if (ed_sum_wide > EdSumMax) begin
                sum_ed_d = {ACC_W{1'b1}};
            end else begin
                sum_ed_d = ed_sum_wide[ACC_W-1:0];
            end
            // The signed sum can move away from a bound, so saturation is made sticky.
            if (!err_sat_q) begin
                if (err_sum_wide > ErrPosLim) begin
                    sum_err_d = ErrPosLim[ACC_W-1:0];
                    err_sat_d = 1'b1;
                end else if (err_sum_wide < ErrNegLim) begin
                    sum_err_d = ErrNegLim[ACC_W-1:0];
                    err_sat_d = 1'b1;
                end else begin
                    sum_err_d = err_sum_wide[ACC_W-1:0];
                end
            end
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            sum_err_q    <= '0;
            err_sat_q    <= 1'b0;
            max_ed_q     <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_ed_q     <= sum_ed_d;
            sum_err_q    <= sum_err_d;
            err_sat_q    <= err_sat_d;
            max_ed_q     <= max_ed_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign sum_err    = sum_err_q;
    assign max_ed     = max_ed_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Scoreboard bench for approx_mult_err_monitor. Four instances cover the batch sizes and
// accumulator widths of interest; one is selected at a time and shares the stimulus bus.
//   0: N_SAMPLES=4, ACC_W=32   1: N_SAMPLES=65536 (default)
//   2: N_SAMPLES=3, ACC_W=32   3: N_SAMPLES=2, ACC_W=8
module tb_approx_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [15:0] in_r;
    logic [1:0]  sel;

    always #5 clk = ~clk;

    logic        st  [4];
    logic        vl  [4];
    logic        rdy [4];
    logic        bsy [4];
    logic        dn  [4];
    logic [16:0] scnt[4];
    logic [16:0] ecnt[4];
    logic [15:0] mxed[4];
    logic [31:0] sed0, sed1, sed2, serr0, serr1, serr2;
    logic [7:0]  sed3, serr3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st[i] = start && (sel == 2'(i));
            vl[i] = in_valid && (sel == 2'(i));
        end
    end

    approx_mult_err_monitor #(.N_SAMPLES(4), .ACC_W(32), .CNT_W(17)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .in_valid(vl[0]), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .in_r(in_r), .busy(bsy[0]), .done(dn[0]),
        .sample_cnt(scnt[0]), .err_cnt(ecnt[0]), .sum_ed(sed0), .sum_err(serr0),
        .max_ed(mxed[0]));

    approx_mult_err_monitor u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .in_valid(vl[1]), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .in_r(in_r), .busy(bsy[1]), .done(dn[1]),
        .sample_cnt(scnt[1]), .err_cnt(ecnt[1]), .sum_ed(sed1), .sum_err(serr1),
        .max_ed(mxed[1]));

    approx_mult_err_monitor #(.N_SAMPLES(3), .ACC_W(32), .CNT_W(17)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .in_valid(vl[2]), .in_ready(rdy[2]),
        .in_a(in_a), .in_b(in_b), .in_r(in_r), .busy(bsy[2]), .done(dn[2]),
        .sample_cnt(scnt[2]), .err_cnt(ecnt[2]), .sum_ed(sed2), .sum_err(serr2),
        .max_ed(mxed[2]));

    approx_mult_err_monitor #(.N_SAMPLES(2), .ACC_W(8), .CNT_W(17)) u_dut3 (
        .clk(clk), .rst(rst), .start(st[3]), .in_valid(vl[3]), .in_ready(rdy[3]),
        .in_a(in_a), .in_b(in_b), .in_r(in_r), .busy(bsy[3]), .done(dn[3]),
        .sample_cnt(scnt[3]), .err_cnt(ecnt[3]), .sum_ed(sed3), .sum_err(serr3),
        .max_ed(mxed[3]));

    // Outputs of the selected instance, widened for comparison.
    logic   ready_obs, busy_obs, done_obs;
    longint o_cnt, o_err, o_sed, o_serr, o_max;

    always_comb begin
        ready_obs = rdy[sel];
        busy_obs  = bsy[sel];
        done_obs  = dn[sel];
        o_cnt     = longint'(scnt[sel]);
        o_err     = longint'(ecnt[sel]);
        o_max     = longint'(mxed[sel]);
        case (sel)
            2'd0:    begin o_sed = longint'(sed0); o_serr = longint'($signed(serr0)); end
            2'd1:    begin o_sed = longint'(sed1); o_serr = longint'($signed(serr1)); end
            2'd2:    begin o_sed = longint'(sed2); o_serr = longint'($signed(serr2)); end
            default: begin o_sed = longint'(sed3); o_serr = longint'($signed(serr3)); end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: batch metrics from plain integer arithmetic
    // ------------------------------------------------------------------
    typedef struct {
        longint cnt;
        longint err;
        longint sed;
        longint serr;
        longint mx;
    } exp_t;

    exp_t   exp_q[$];
    longint n_samp[4] = '{4, 65536, 3, 2};
    int     acc_w [4] = '{32, 32, 32, 8};
    longint m_cnt, m_err, m_sed, m_serr, m_max;
    bit     m_sat;

    task automatic model_start();
        m_cnt = 0; m_err = 0; m_sed = 0; m_serr = 0; m_max = 0; m_sat = 1'b0;
    endtask

    task automatic model_add(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        longint exact, e, ed, ed_lim, pos_lim, neg_lim, s;
        exact   = longint'(a) * longint'(b);
        e       = longint'(r) - exact;
        ed      = (e < 0) ? -e : e;
        ed_lim  = (longint'(1) << acc_w[sel]) - 1;
        pos_lim = (longint'(1) << (acc_w[sel] - 1)) - 1;
        neg_lim = -(longint'(1) << (acc_w[sel] - 1));
        m_cnt++;
        if (ed != 0) m_err++;
        m_sed = (m_sed + ed > ed_lim) ? ed_lim : m_sed + ed;
        if (!m_sat) begin
            s = m_serr + e;
            if (s > pos_lim) begin
                m_serr = pos_lim; m_sat = 1'b1;
            end else if (s < neg_lim) begin
                m_serr = neg_lim; m_sat = 1'b1;
            end else begin
                m_serr = s;
            end
        end
        if (ed > m_max) m_max = ed;
        if (m_cnt == n_samp[sel]) begin
            exp_q.push_back('{cnt: m_cnt, err: m_err, sed: m_sed, serr: m_serr, mx: m_max});
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever the selected instance raises done
    // ------------------------------------------------------------------
    longint edge_idx = 0;
    longint last_xfer_edge = 0;
    logic   dn_prev[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_idx++;
            if (in_valid && ready_obs) last_xfer_edge = edge_idx;
            #1;
            if (done_obs && !dn_prev[sel]) begin
                check("sb_depth", longint'(exp_q.size()), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sample_cnt", o_cnt, e.cnt);
                    check("err_cnt", o_err, e.err);
                    check("sum_ed", o_sed, e.sed);
                    check("sum_err", o_serr, e.serr);
                    check("max_ed", o_max, e.mx);
                    check("done_latency", edge_idx - last_xfer_edge + 1, 3);
                end
            end
            for (int i = 0; i < 4; i++) dn_prev[i] = dn[i];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic begin_batch();
        model_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        int n = 0;
        in_a = a; in_b = b; in_r = r; in_valid = 1'b1;
        model_add(a, b, r);
        while (!ready_obs && n < 50) begin
            tick(1);
            n++;
        end
        check("send_accept", longint'(ready_obs), 1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic rand_sample(output logic [7:0] a, output logic [7:0] b,
                               output logic [15:0] r);
        int exact, rr;
        a = 8'($urandom);
        b = 8'($urandom);
        exact = int'(a) * int'(b);
        case ($urandom_range(0, 2))
            0: rr = exact;
            1: rr = exact + int'($urandom_range(0, 16)) - 8;
            default: rr = int'($urandom_range(0, 65535));
        endcase
        if (rr < 0) rr = 0;
        if (rr > 65535) rr = 65535;
        r = 16'(rr);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_obs && n < 100) begin
            tick(1);
            n++;
        end
        check({name, "_busy_low"}, longint'(busy_obs), 0);
        check({name, "_done_high"}, longint'(done_obs), 1);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_ready"}, longint'(ready_obs), 0);
        check({name, "_busy"}, longint'(busy_obs), 0);
        check({name, "_done"}, longint'(done_obs), 0);
        check({name, "_cnt"}, o_cnt, 0);
        check({name, "_err"}, o_err, 0);
        check({name, "_sed"}, o_sed, 0);
        check({name, "_serr"}, o_serr, 0);
        check({name, "_max"}, o_max, 0);
    endtask

    // Hard stop if anything stalls beyond any plausible schedule.
    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  a, b;
        logic [15:0] r;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_r = '0; sel = 2'd0;
        tick(3);
        check_cleared("reset");
        rst = 1'b0;
        tick(1);

        // Directed batch, back-to-back transfers.
        begin_batch();
        send(8'd3, 8'd5, 16'd15);
        send(8'd3, 8'd5, 16'd13);
        send(8'd255, 8'd255, 16'd65025);
        send(8'd10, 8'd10, 16'd104);
        check("ready_drop_n4", longint'(ready_obs), 0);
        wait_idle("directed");

        // start during RUN must not clear or restart the batch.
        begin_batch();
        for (int i = 0; i < 2; i++) begin
            rand_sample(a, b, r);
            send(a, b, r);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_ignored_cnt", o_cnt, 2);
        check("start_ignored_busy", longint'(busy_obs), 1);
        for (int i = 0; i < 2; i++) begin
            rand_sample(a, b, r);
            send(a, b, r);
        end
        wait_idle("start_ignored");

        // Asynchronous reset between the 2nd and 3rd samples.
        begin_batch();
        for (int i = 0; i < 2; i++) begin
            rand_sample(a, b, r);
            send(a, b, r);
        end
        tick(1);
        rst = 1'b1;
        #1;
        check_cleared("mid_rst");
        tick(1);
        rst = 1'b0;
        tick(1);
        begin_batch();
        for (int i = 0; i < 4; i++) begin
            rand_sample(a, b, r);
            send(a, b, r);
        end
        wait_idle("after_rst");

        // Random batches with random idle gaps.
        for (int k = 0; k < 8; k++) begin
            begin_batch();
            for (int i = 0; i < 4; i++) begin
                rand_sample(a, b, r);
                send(a, b, r);
                tick($urandom_range(0, 2));
            end
            wait_idle("random");
        end

        // Throttled valid, every result one above exact.
        sel = 2'd2;
        tick(1);
        begin_batch();
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send(a, b, 16'(int'(a) * int'(b) + 1));
            if (i < 2) tick(2);
        end
        check("ready_drop_n3", longint'(ready_obs), 0);
        wait_idle("throttled");

        // Saturation with 8-bit accumulators.
        sel = 2'd3;
        tick(1);
        begin_batch();
        send(8'd0, 8'd0, 16'd200);
        send(8'd0, 8'd0, 16'd200);
        wait_idle("saturate");

        // Exhaustive sweep with exact results.
        sel = 2'd1;
        tick(1);
        begin_batch();
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                send(8'(i), 8'(j), 16'(i * j));
            end
        end
        wait_idle("exhaustive");

        tick(2);
        check("sb_drained", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
